// File: rtl/exibicao_display.sv
// Seven-segment back-end for the display memory: signed decimal or hex image of a 32-bit word,
// plus a debounced single-cycle "next" pulse from the physical key.
module exibicao_display #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic [31:0] valor,
    input  logic        botao,
    input  logic        modo,
    output logic        proximo,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7
);
    typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;

    function automatic logic [6:0] seg_hex(input logic [3:0] n);
        case (n)
            4'h0: seg_hex = 7'h40;
            4'h1: seg_hex = 7'h79;
            4'h2: seg_hex = 7'h24;
            4'h3: seg_hex = 7'h30;
            4'h4: seg_hex = 7'h19;
            4'h5: seg_hex = 7'h12;
            4'h6: seg_hex = 7'h02;
            4'h7: seg_hex = 7'h78;
            4'h8: seg_hex = 7'h00;
            4'h9: seg_hex = 7'h10;
            4'hA: seg_hex = 7'h08;
            4'hB: seg_hex = 7'h03;
            4'hC: seg_hex = 7'h46;
            4'hD: seg_hex = 7'h21;
            4'hE: seg_hex = 7'h06;
            default: seg_hex = 7'h0E;
        endcase
    endfunction

    // Key path: synchronizer, stability counter, rising-edge detect on the accepted level.
    logic             botao_s1, botao_s2;
    logic             nivel, nivel_d;
    logic [CNT_W-1:0] deb_cnt;

    // NOTE: every register here has an async reset branch and uses <= so all
    // flops update together from pre-edge values; blocking = would chain them.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            botao_s1 <= 1'b0;
            botao_s2 <= 1'b0;
            nivel    <= 1'b0;
            nivel_d  <= 1'b0;
            deb_cnt  <= '0;
            proximo  <= 1'b0;
        end else begin
            botao_s1 <= botao;
            botao_s2 <= botao_s1;
            nivel_d  <= nivel;
            proximo  <= nivel & ~nivel_d;
            if (botao_s2 == nivel) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CNT_MAX) begin
                nivel   <= ~nivel;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
        end
    end

    logic modo_s1, modo_s2;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            modo_s1 <= 1'b0;
            modo_s2 <= 1'b0;
        end else begin
            modo_s1 <= modo;
            modo_s2 <= modo_s1;
        end
    end

    // Conversion datapath: {10 BCD nibbles, 32-bit binary} shifted left once per CONV cycle.
    state_t      state;
    logic [31:0] cap_valor;
    logic        cap_modo;
    logic        force_conv;
    logic [71:0] shreg, shreg_next;
    logic [4:0]  iter;
    logic [6:0]  hex_r [8];
    logic [6:0]  img   [8];
    logic [31:0] mag;
    logic [39:0] bcd_adj;
    logic        overflow;
    logic        lead_zero;

    assign mag      = valor[31] ? (32'd0 - valor) : valor;
    assign overflow = |shreg[71:60];

    // NOTE: every variable written in a combinational block gets a default at
    // the top, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        bcd_adj = shreg[71:32];
        for (int i = 0; i < 10; i++) begin
            if (bcd_adj[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
        end
        shreg_next = {bcd_adj, shreg[31:0]} << 1;
    end

    always_comb begin
        lead_zero = 1'b1;
        for (int i = 0; i < 8; i++) img[i] = SEG_BLANK;
        if (cap_modo) begin
            for (int i = 0; i < 8; i++) img[i] = seg_hex(cap_valor[4*i +: 4]);
        end else if (overflow) begin
            img[2] = SEG_E;
            img[1] = SEG_R;
            img[0] = SEG_R;
        end else begin
            for (int i = 6; i >= 1; i--) begin
                if (shreg[32+4*i +: 4] != 4'd0) lead_zero = 1'b0;
                img[i] = lead_zero ? SEG_BLANK : seg_hex(shreg[32+4*i +: 4]);
            end
            img[0] = seg_hex(shreg[35:32]);
            img[7] = cap_valor[31] ? SEG_MINUS : SEG_BLANK;
        end
    end

    // force_conv makes the first image after reset appear even when valor is 0.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cap_valor  <= '0;
            cap_modo   <= 1'b0;
            force_conv <= 1'b1;
            shreg      <= '0;
            iter       <= '0;
            for (int i = 0; i < 8; i++) hex_r[i] <= SEG_BLANK;
        end else begin
            case (state)
                IDLE: begin
                    if (valor != cap_valor || modo_s2 != cap_modo || force_conv) begin
                        cap_valor  <= valor;
                        cap_modo   <= modo_s2;
                        force_conv <= 1'b0;
                        shreg      <= {40'd0, mag};
                        iter       <= '0;
                        state      <= CONV;
                    end
                end
                CONV: begin
                    shreg <= shreg_next;
                    iter  <= iter + 5'd1;
                    if (iter == 5'd31) state <= SHOW;
                end
                SHOW: begin
                    for (int i = 0; i < 8; i++) hex_r[i] <= img[i];
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign hex0 = hex_r[0];
    assign hex1 = hex_r[1];
    assign hex2 = hex_r[2];
    assign hex3 = hex_r[3];
    assign hex4 = hex_r[4];
    assign hex5 = hex_r[5];
    assign hex6 = hex_r[6];
    assign hex7 = hex_r[7];

endmodule

// File: tb/tb_exibicao_display.sv
// Directed bench for exibicao_display: display images, conversion latency, debounce and reset.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_exibicao_display;
    logic        Clk;
    logic        reset;
    logic [31:0] valor;
    logic        botao;
    logic        modo;
    logic        proximo;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] BL = 7'h7F;

    exibicao_display #(.DEBOUNCE_CYCLES(8)) dut (
        .Clk     (Clk),
        .reset   (reset),
        .valor   (valor),
        .botao   (botao),
        .modo    (modo),
        .proximo (proximo),
        .hex0    (hex0),
        .hex1    (hex1),
        .hex2    (hex2),
        .hex3    (hex3),
        .hex4    (hex4),
        .hex5    (hex5),
        .hex6    (hex6),
        .hex7    (hex7)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [55:0] pack8(input logic [6:0] a7, input logic [6:0] a6,
                                          input logic [6:0] a5, input logic [6:0] a4,
                                          input logic [6:0] a3, input logic [6:0] a2,
                                          input logic [6:0] a1, input logic [6:0] a0);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [55:0] disp();
        return {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};
    endfunction

    // Advance n rising edges, ending on a falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            @(negedge Clk);
        end
    endtask

    // Hold botao for 'hold' edges out of 'n', recording the edge of the first proximo sample and how many were high.
    task automatic press_watch(input int hold, input int n, output int first, output int cnt);
        first = -1;
        cnt   = 0;
        botao = 1'b1;
        for (int k = 1; k <= n; k++) begin
            if (k > hold) botao = 1'b0;
            step(1);
            if (proximo === 1'b1) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        botao = 1'b0;
    endtask

    task automatic test_reset();
        logic [55:0] exp_img;
        reset = 1'b1;
        valor = 32'd0;
        modo  = 1'b0;
        botao = 1'b0;
        step(2);
        exp_img = pack8(BL, BL, BL, BL, BL, BL, BL, BL);
        checks++;
        if (disp() !== exp_img) begin
            failures++;
            $display("FAIL reset_blank: got %h expected %h", disp(), exp_img);
        end
        checks++;
        if (proximo !== 1'b0) begin
            failures++;
            $display("FAIL reset_proximo: got %b expected 0", proximo);
        end
        reset = 1'b0;
        step(33);
        checks++;
        if (disp() !== exp_img) begin
            failures++;
            $display("FAIL startup_edge33: got %h expected %h", disp(), exp_img);
        end
        step(1);
        exp_img = pack8(BL, BL, BL, BL, BL, BL, BL, 7'h40);
        checks++;
        if (disp() !== exp_img) begin
            failures++;
            $display("FAIL startup_zero: got %h expected %h", disp(), exp_img);
        end
    endtask

    task automatic test_decimal_negative();
        logic [55:0] exp_img;
        valor = 32'hFFFF_FB2E;
        step(33);
        exp_img = pack8(BL, BL, BL, BL, BL, BL, BL, 7'h40);
        checks++;
        if (disp() !== exp_img) begin
            failures++;
            $display("FAIL neg_hold_old: got %h expected %h", disp(), exp_img);
        end
        step(1);
        exp_img = pack8(7'h3F, BL, BL, BL, 7'h79, 7'h24, 7'h30, 7'h19);
        checks++;
        if (disp() !== exp_img) begin
            failures++;
            $display("FAIL neg_1234: got %h expected %h", disp(), exp_img);
        end
    endtask

    task automatic test_hex_overflow();
        logic [55:0] err_img, hex_img;
        err_img = pack8(BL, BL, BL, BL, BL, 7'h06, 7'h2F, 7'h2F);
        hex_img = pack8(7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E);
        // valor is seen immediately, modo only after its synchronizer: decimal first, then hex.
        modo  = 1'b1;
        valor = 32'hDEAD_BEEF;
        step(34);
        checks++;
        if (disp() !== err_img) begin
            failures++;
            $display("FAIL deadbeef_dec_first: got %h expected %h", disp(), err_img);
        end
        step(34);
        checks++;
        if (disp() !== hex_img) begin
            failures++;
            $display("FAIL deadbeef_hex: got %h expected %h", disp(), hex_img);
        end
        modo = 1'b0;
        step(35);
        checks++;
        if (disp() !== hex_img) begin
            failures++;
            $display("FAIL modo_sync_latency: got %h expected %h", disp(), hex_img);
        end
        step(1);
        checks++;
        if (disp() !== err_img) begin
            failures++;
            $display("FAIL deadbeef_err: got %h expected %h", disp(), err_img);
        end
    endtask

    task automatic test_overflow_boundary();
        logic [55:0] err_img;
        err_img = pack8(BL, BL, BL, BL, BL, 7'h06, 7'h2F, 7'h2F);
        valor = 32'd10000000;
        step(34);
        checks++;
        if (disp() !== err_img) begin
            failures++;
            $display("FAIL ten_million_err: got %h expected %h", disp(), err_img);
        end
        valor = 32'h8000_0000;
        step(34);
        checks++;
        if (disp() !== err_img) begin
            failures++;
            $display("FAIL most_negative_err: got %h expected %h", disp(), err_img);
        end
    endtask

    task automatic test_mid_conversion();
        logic [55:0] exp_img;
        valor = 32'd5;
        step(11);
        valor = 32'd9999999;
        step(23);
        exp_img = pack8(BL, BL, BL, BL, BL, BL, BL, 7'h12);
        checks++;
        if (disp() !== exp_img) begin
            failures++;
            $display("FAIL mid_conv_first: got %h expected %h", disp(), exp_img);
        end
        step(34);
        exp_img = pack8(BL, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10);
        checks++;
        if (disp() !== exp_img) begin
            failures++;
            $display("FAIL mid_conv_second: got %h expected %h", disp(), exp_img);
        end
    endtask

    task automatic test_debounce();
        int first, cnt;
        press_watch(5, 30, first, cnt);
        checks++;
        if (cnt !== 0) begin
            failures++;
            $display("FAIL glitch_pulses: got %0d expected 0", cnt);
        end
        press_watch(20, 40, first, cnt);
        checks++;
        if (cnt !== 1) begin
            failures++;
            $display("FAIL press_pulses: got %0d expected 1", cnt);
        end
        checks++;
        if (first !== 11) begin
            failures++;
            $display("FAIL press_latency: got %0d expected 11", first);
        end
    endtask

    task automatic test_held_key();
        int first, cnt;
        press_watch(200, 230, first, cnt);
        checks++;
        if (cnt !== 1) begin
            failures++;
            $display("FAIL held_pulses: got %0d expected 1", cnt);
        end
        checks++;
        if (first !== 11) begin
            failures++;
            $display("FAIL held_latency: got %0d expected 11", first);
        end
    endtask

    // Key press and conversion run together; reset lands on the pulse cycle mid-conversion.
    task automatic test_back_to_back();
        logic [55:0] exp_img;
        int first, cnt;
        valor = 32'd42;
        botao = 1'b1;
        step(11);
        checks++;
        if (proximo !== 1'b1) begin
            failures++;
            $display("FAIL pulse_during_conv: got %b expected 1", proximo);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (proximo !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_proximo: got %b expected 0", proximo);
        end
        exp_img = pack8(BL, BL, BL, BL, BL, BL, BL, BL);
        checks++;
        if (disp() !== exp_img) begin
            failures++;
            $display("FAIL reset_mid_conv_blank: got %h expected %h", disp(), exp_img);
        end
        step(2);
        reset = 1'b0;
        first = -1;
        cnt   = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            if (proximo === 1'b1) begin
                cnt++;
                if (first < 0) first = k;
            end
            if (k == 34) begin
                exp_img = pack8(BL, BL, BL, BL, BL, BL, 7'h19, 7'h24);
                checks++;
                if (disp() !== exp_img) begin
                    failures++;
                    $display("FAIL restart_42: got %h expected %h", disp(), exp_img);
                end
            end
        end
        botao = 1'b0;
        checks++;
        if (cnt !== 1 || first !== 11) begin
            failures++;
            $display("FAIL repress_after_reset: got count=%0d edge=%0d expected count=1 edge=11", cnt, first);
        end
    endtask

    initial begin
        test_reset();
        test_decimal_negative();
        test_hex_overflow();
        test_overflow_boundary();
        test_mid_conversion();
        test_debounce();
        test_held_key();
        test_back_to_back();
        step(20);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
